// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit 7-segment scan back into a 16-bit hex value.
// Inputs are synchronized and debounced; a completed digit-0..3 sequence yields one frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [3:0]  i_dig_sel,
    input  logic [6:0]  i_seg,
    output logic [15:0] o_value,
    output logic        o_valid,
    output logic        o_err,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_HIT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_D0 = 3'd0,
        WAIT_D1 = 3'd1,
        WAIT_D2 = 3'd2,
        WAIT_D3 = 3'd3,
        UPDATE  = 3'd4
    } state_t;

    logic [3:0]  r_dig_s1, r_dig_s2;
    logic [6:0]  r_seg_s1, r_seg_s2;
    logic [10:0] r_prev;
    logic [7:0]  r_stab_cnt;
    logic        r_err_flag;
    state_t      r_state;

    logic [10:0] w_cur;
    logic        w_same;
    logic        w_accept;
    logic        w_onehot;
    logic [1:0]  w_dig_idx;
    logic        w_seg_bad;
    logic [3:0]  w_dec_nib;
    logic        w_store_en;
    logic        w_err_next;
    state_t      w_state_next;
    logic [15:0] w_nibs;

    assign w_cur  = {r_dig_s2, r_seg_s2};
    assign w_same = (w_cur == r_prev);
    // Fires exactly once per dwell: the edge on which the counter steps onto STABLE_CYCLES.
    assign w_accept = w_same && (r_stab_cnt == STABLE_HIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dig_s1   <= '1;
            r_dig_s2   <= '1;
            r_seg_s1   <= '1;
            r_seg_s2   <= '1;
            r_prev     <= '1;
            r_stab_cnt <= '0;
        end else begin
            r_dig_s1 <= i_dig_sel;
            r_dig_s2 <= r_dig_s1;
            r_seg_s1 <= i_seg;
            r_seg_s2 <= r_seg_s1;
            r_prev   <= w_cur;
            if (!w_same) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STABLE_MAX) begin
                r_stab_cnt <= r_stab_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_onehot  = 1'b1;
        w_dig_idx = 2'd0;
        case (r_dig_s2)
            4'b1110: w_dig_idx = 2'd0;
            4'b1101: w_dig_idx = 2'd1;
            4'b1011: w_dig_idx = 2'd2;
            4'b0111: w_dig_idx = 2'd3;
            default: w_onehot  = 1'b0;
        endcase
    end

    always_comb begin
        w_seg_bad = 1'b0;
        w_dec_nib = 4'h0;
        case (r_seg_s2)
            7'h40: w_dec_nib = 4'h0;
            7'h79: w_dec_nib = 4'h1;
            7'h24: w_dec_nib = 4'h2;
            7'h30: w_dec_nib = 4'h3;
            7'h19: w_dec_nib = 4'h4;
            7'h12: w_dec_nib = 4'h5;
            7'h02: w_dec_nib = 4'h6;
            7'h78: w_dec_nib = 4'h7;
            7'h00: w_dec_nib = 4'h8;
            7'h10: w_dec_nib = 4'h9;
            7'h08: w_dec_nib = 4'hA;
            7'h03: w_dec_nib = 4'hB;
            7'h46: w_dec_nib = 4'hC;
            7'h21: w_dec_nib = 4'hD;
            7'h06: w_dec_nib = 4'hE;
            7'h0E: w_dec_nib = 4'hF;
            default: w_seg_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_store_en   = 1'b0;
        w_err_next   = r_err_flag;
        case (r_state)
            WAIT_D0: begin
                if (w_accept && w_onehot && w_dig_idx == 2'd0) begin
                    w_store_en   = 1'b1;
                    w_err_next   = w_seg_bad;
                    w_state_next = WAIT_D1;
                end
            end
            WAIT_D1, WAIT_D2, WAIT_D3: begin
                if (w_accept && w_onehot) begin
                    if (w_dig_idx == r_state[1:0]) begin
                        w_store_en   = 1'b1;
                        w_err_next   = r_err_flag | w_seg_bad;
                        w_state_next = (r_state == WAIT_D3) ? UPDATE : state_t'(r_state + 3'd1);
                    end else if (w_dig_idx == 2'd0) begin
                        // Digit 0 out of order restarts the frame from this digit.
                        w_store_en   = 1'b1;
                        w_err_next   = w_seg_bad;
                        w_state_next = WAIT_D1;
                    end else begin
                        w_err_next   = 1'b0;
                        w_state_next = WAIT_D0;
                    end
                end
            end
            UPDATE: begin
                w_err_next   = 1'b0;
                w_state_next = WAIT_D0;
            end
            default: begin
                w_err_next   = 1'b0;
                w_state_next = WAIT_D0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= WAIT_D0;
            r_err_flag <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_err_flag <= w_err_next;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
        logic [3:0] r_nib;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_nib <= 4'h0;
            end else if (w_store_en && w_dig_idx == 2'(gi)) begin
                r_nib <= w_dec_nib;
            end
        end
        assign w_nibs[4*gi +: 4] = r_nib;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_value     <= 16'h0000;
            o_valid     <= 1'b0;
            o_err       <= 1'b0;
            o_frame_cnt <= 8'h00;
        end else if (r_state == UPDATE) begin
            o_value     <= w_nibs;
            o_valid     <= 1'b1;
            o_err       <= r_err_flag;
            o_frame_cnt <= o_frame_cnt + 8'd1;
        end else begin
            o_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized and directed bench for seg_scan_decoder; a transaction-level model predicts frames
// from (digit, pattern, hold length) triples.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_dig_sel = 4'hF;
    logic [6:0]  i_seg = 7'h7F;
    logic [15:0] o_value;
    logic        o_valid;
    logic        o_err;
    logic [7:0]  o_frame_cnt;

    int checks = 0;
    int errors = 0;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dig_sel(i_dig_sel), .i_seg(i_seg),
        .o_value(o_value), .o_valid(o_valid), .o_err(o_err), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int          m_pos;
    int          m_dig [4];
    bit          m_err;
    int          m_frames;
    logic [10:0] m_last;
    int          m_run_len;
    bit          m_acc_done;
    logic [15:0] exp_val [$];
    bit          exp_err [$];
    logic [7:0]  exp_cnt [$];
    logic [15:0] act_val [$];
    bit          act_err [$];
    logic [7:0]  act_cnt [$];

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            act_val.push_back(o_value);
            act_err.push_back(o_err);
            act_cnt.push_back(o_frame_cnt);
        end
    end

    function automatic int dec(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (tbl[i] == s) return i;
        return -1;
    endfunction

    function automatic int dig_pos(input logic [3:0] d);
        case (d)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        m_pos = 0; m_err = 0; m_frames = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_last = 11'h7FF; m_run_len = 1000; m_acc_done = 1;
        exp_val.delete(); exp_err.delete(); exp_cnt.delete();
        act_val.delete(); act_err.delete(); act_cnt.delete();
    endtask

    task automatic model_accept(input int k, input int v);
        bit bad = (v < 0);
        int nib = bad ? 0 : v;
        if (m_pos == 0) begin
            if (k == 0) begin m_dig[0] = nib; m_err = bad; m_pos = 1; end
        end else if (k == m_pos) begin
            m_dig[k] = nib; m_err = m_err | bad; m_pos++;
            if (m_pos == 4) begin
                m_frames = (m_frames + 1) % 256;
                exp_val.push_back({m_dig[3][3:0], m_dig[2][3:0], m_dig[1][3:0], m_dig[0][3:0]});
                exp_err.push_back(m_err);
                exp_cnt.push_back(8'(m_frames));
                m_err = 0; m_pos = 0;
            end
        end else if (k == 0) begin
            m_dig[0] = nib; m_err = bad; m_pos = 1;
        end else begin
            m_err = 0; m_pos = 0;
        end
    endtask

    // A pattern is accepted once it has been present for S+1 sampled cycles in a row.
    task automatic model_hold(input logic [3:0] dig, input logic [6:0] seg, input int len);
        if ({dig, seg} == m_last) m_run_len += len;
        else begin m_run_len = len; m_acc_done = 0; end
        m_last = {dig, seg};
        if (!m_acc_done && m_run_len >= S + 1) begin
            m_acc_done = 1;
            if (dig_pos(dig) >= 0) model_accept(dig_pos(dig), dec(seg));
        end
    endtask

    task automatic hold(input logic [3:0] dig, input logic [6:0] seg, input int len);
        i_dig_sel = dig; i_seg = seg;
        repeat (len) @(posedge clk);
        #1;
        model_hold(dig, seg, len);
    endtask

    task automatic flush_and_clear();
        hold(4'hF, 7'h7F, S + 8);
        exp_val.delete(); exp_err.delete(); exp_cnt.delete();
        act_val.delete(); act_err.delete(); act_cnt.delete();
    endtask

    task automatic test_reset();
        rst_n = 0; model_reset();
        repeat (3) @(negedge clk);
        checks++; if (o_value !== 16'h0) begin errors++; $display("FAIL reset_value got %h want 0000", o_value); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
        checks++; if (o_frame_cnt !== 8'h0) begin errors++; $display("FAIL reset_cnt got %h want 00", o_frame_cnt); end
        @(posedge clk); #1; rst_n = 1;
        repeat (2) @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        hold(4'b1110, 7'h30, 8); hold(4'b1101, 7'h24, 8);
        hold(4'b1011, 7'h79, 8); hold(4'b0111, 7'h40, 8);
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", act_val.size()); end
        checks++; if (o_value !== 16'h0123 || o_err !== 1'b0 || o_frame_cnt !== 8'd1) begin
            errors++; $display("FAIL basic_frame got %h/%b/%0d want 0123/0/1", o_value, o_err, o_frame_cnt); end
        checks++; if (exp_val.size() != 1 || exp_val[0] !== 16'h0123) begin errors++; $display("FAIL basic_model got %0d frames want 1", exp_val.size()); end
        $display("test_basic value=%h err=%b cnt=%0d", o_value, o_err, o_frame_cnt);
    endtask

    task automatic test_table();
        logic [15:0] want [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
        logic [3:0] d;
        flush_and_clear();
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 4; k++) begin
                d = 4'b0001 << k;
                hold(~d, tbl[4*f+k], 8);
            end
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != 4) begin errors++; $display("FAIL table_pulses got %0d want 4", act_val.size()); end
        for (int i = 0; i < 4 && i < act_val.size(); i++) begin
            checks++;
            if (act_val[i] !== want[i] || act_err[i] !== 1'b0 || act_cnt[i] !== exp_cnt[i]) begin
                errors++; $display("FAIL table_frame%0d got %h/%b/%0d want %h/0/%0d", i, act_val[i], act_err[i], act_cnt[i], want[i], exp_cnt[i]); end
            $display("table frame %0d value=%h err=%b cnt=%0d", i, act_val[i], act_err[i], act_cnt[i]);
        end
    endtask

    task automatic test_error();
        flush_and_clear();
        hold(4'b1110, 7'h79, 8); hold(4'b1101, 7'h24, 8);
        hold(4'b1011, 7'h7F, 8); hold(4'b0111, 7'h30, 8);
        hold(4'b1110, 7'h40, 8); hold(4'b1101, 7'h79, 8);
        hold(4'b1011, 7'h24, 8); hold(4'b0111, 7'h30, 8);
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != 2) begin errors++; $display("FAIL error_pulses got %0d want 2", act_val.size()); end
        if (act_val.size() == 2) begin
            checks++; if (act_val[0] !== 16'h3021 || act_err[0] !== 1'b1) begin
                errors++; $display("FAIL error_bad_frame got %h/%b want 3021/1", act_val[0], act_err[0]); end
            checks++; if (act_val[1] !== 16'h3210 || act_err[1] !== 1'b0) begin
                errors++; $display("FAIL error_clean_frame got %h/%b want 3210/0", act_val[1], act_err[1]); end
            $display("error frames %h/%b then %h/%b", act_val[0], act_err[0], act_val[1], act_err[1]);
        end
        checks++; if (o_err !== 1'b0 || o_value !== 16'h3210) begin errors++; $display("FAIL error_hold got %h/%b want 3210/0", o_value, o_err); end
    endtask

    task automatic test_glitch();
        flush_and_clear();
        hold(4'b1110, 7'h19, 8);
        for (int i = 0; i < 6; i++) hold(4'b1101, (i % 2 == 0) ? 7'h12 : 7'h02, 2);
        checks++; if (dut.r_state !== 3'd1) begin errors++; $display("FAIL glitch_no_accept state got %0d want 1", dut.r_state); end
        hold(4'b1101, 7'h12, 8); hold(4'b1011, 7'h78, 8); hold(4'b0111, 7'h00, 8);
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != 1) begin errors++; $display("FAIL glitch_pulses got %0d want 1", act_val.size()); end
        else begin
            checks++; if (act_val[0] !== 16'h8754 || act_err[0] !== 1'b0) begin
                errors++; $display("FAIL glitch_frame got %h/%b want 8754/0", act_val[0], act_err[0]); end
            $display("glitch frame value=%h err=%b", act_val[0], act_err[0]);
        end
    endtask

    task automatic test_resync();
        flush_and_clear();
        hold(4'b1110, 7'h08, 8); hold(4'b1101, 7'h03, 8);
        hold(4'b1110, 7'h46, 8); hold(4'b1101, 7'h21, 8);
        hold(4'b1011, 7'h06, 8); hold(4'b0111, 7'h0E, 8);
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != 1) begin errors++; $display("FAIL resync_pulses got %0d want 1", act_val.size()); end
        else begin
            checks++; if (act_val[0] !== 16'hFEDC || act_val[0] !== exp_val[0]) begin
                errors++; $display("FAIL resync_frame got %h want FEDC", act_val[0]); end
            $display("resync frame value=%h", act_val[0]);
        end
    endtask

    task automatic test_latency();
        int n = 0;
        bit seen = 0;
        flush_and_clear();
        hold(4'b1110, 7'h40, 8); hold(4'b1101, 7'h79, 8); hold(4'b1011, 7'h24, 8);
        i_dig_sel = 4'b0111; i_seg = 7'h30;
        while (!seen && n < 50) begin
            @(posedge clk); #1; n++;
            if (o_valid) seen = 1;
        end
        repeat (2) @(posedge clk); #1;
        model_hold(4'b0111, 7'h30, n + 2);
        // First sampling edge, then two synchronizer stages, S stable cycles and the UPDATE cycle.
        checks++; if (!seen || n != S + 4) begin errors++; $display("FAIL latency got %0d edges (seen=%b) want %0d", n, seen, S + 4); end
        $display("latency edges=%0d", n);
        hold(4'hF, 7'h7F, S + 8);
    endtask

    task automatic test_random();
        int c = 0;
        logic [3:0] d;
        logic [6:0] sg;
        int r;
        flush_and_clear();
        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 99));
            if (r < 75) begin d = 4'b0001 << c; d = ~d; c = (c + 1) % 4; end
            else if (r < 85) d = 4'hF;
            else d = 4'($urandom);
            sg = ($urandom_range(0, 99) < 85) ? tbl[$urandom_range(0, 15)] : 7'($urandom);
            hold(d, sg, int'($urandom_range(S - 1, S + 4)));
        end
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != exp_val.size()) begin
            errors++; $display("FAIL random_pulses got %0d want %0d", act_val.size(), exp_val.size()); end
        for (int i = 0; i < exp_val.size() && i < act_val.size(); i++) begin
            checks++;
            if (act_val[i] !== exp_val[i] || act_err[i] !== exp_err[i] || act_cnt[i] !== exp_cnt[i]) begin
                errors++; $display("FAIL random_frame%0d got %h/%b/%0d want %h/%b/%0d", i, act_val[i], act_err[i], act_cnt[i], exp_val[i], exp_err[i], exp_cnt[i]); end
            $display("random frame %0d value=%h err=%b cnt=%0d", i, act_val[i], act_err[i], act_cnt[i]);
        end
    endtask

    task automatic test_reset_wrap();
        logic [3:0] d;
        flush_and_clear();
        hold(4'b1110, 7'h40, 8); hold(4'b1101, 7'h79, 8);
        #2; rst_n = 0; #1;
        checks++; if (o_value !== 16'h0 || o_valid !== 1'b0 || o_err !== 1'b0 || o_frame_cnt !== 8'h0) begin
            errors++; $display("FAIL async_reset got %h/%b/%b/%0d want 0000/0/0/0", o_value, o_valid, o_err, o_frame_cnt); end
        i_dig_sel = 4'hF; i_seg = 7'h7F;
        @(posedge clk); #1; rst_n = 1; model_reset();
        hold(4'b1011, 7'h24, 8); hold(4'b0111, 7'h30, 8);
        checks++; if (act_val.size() != 0) begin errors++; $display("FAIL reset_partial got %0d pulses want 0", act_val.size()); end
        for (int f = 0; f < 256; f++)
            for (int k = 0; k < 4; k++) begin
                d = 4'b0001 << k;
                hold(~d, tbl[$urandom_range(0, 15)], S + 1);
            end
        hold(4'hF, 7'h7F, S + 8);
        checks++; if (act_val.size() != 256) begin errors++; $display("FAIL wrap_pulses got %0d want 256", act_val.size()); end
        for (int i = 0; i < exp_val.size() && i < act_val.size(); i++) begin
            checks++;
            if (act_val[i] !== exp_val[i] || act_err[i] !== exp_err[i] || act_cnt[i] !== exp_cnt[i]) begin
                errors++; $display("FAIL wrap_frame%0d got %h/%b/%0d want %h/%b/%0d", i, act_val[i], act_err[i], act_cnt[i], exp_val[i], exp_err[i], exp_cnt[i]); end
        end
        checks++; if (o_frame_cnt !== 8'h00) begin errors++; $display("FAIL wrap_cnt got %0d want 0", o_frame_cnt); end
        $display("wrap done frames=%0d cnt=%0d", act_val.size(), o_frame_cnt);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_error();
        test_glitch();
        test_resync();
        test_latency();
        test_random();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
